// File: rtl/relobi_pkg.sv
// relobi_pkg
// Shared types and helpers for the relobi interconnect blocks.
//   obi_cfg_t / ObiDefaultConfig : bus configuration (UseRReady selects the R handshake)
//   obi_a_chan_t / obi_r_chan_t  : default A and R channel payloads
//   obi_req_t / obi_rsp_t        : default request / response structs
//   idx_width(n)                 : index width for n items, never below 1
//   id_entry_t                   : widest source index an ID FIFO entry can carry
package relobi_pkg;

    typedef struct packed {
        bit          UseRReady;
        int unsigned AddrWidth;
        int unsigned DataWidth;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{UseRReady: 1'b1, AddrWidth: 32, DataWidth: 32};

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_a_chan_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } obi_r_chan_t;

    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
        logic        rready;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Source index stored per outstanding transaction; muxes keep only the
    // low idx_width(NumSbrPorts) bits of it.
    localparam int unsigned IdEntryMaxW = 8;
    typedef logic [IdEntryMaxW-1:0] id_entry_t;

endpackage

// File: rtl/relobi_rr_arb.sv
// relobi_rr_arb
// N-way round-robin arbiter with a lock input.
//   clk_i, rst_ni  : clock, async active-low reset
//   req_i          : request vector
//   lock_i         : hold the previous selection (request waiting for grant)
//   lock_sel_i     : selection to hold while locked
//   hs_i           : handshake on the selected request; advances the pointer
//   sel_o, valid_o : selected index and whether it is requesting
module relobi_rr_arb
    import relobi_pkg::*;
#(
    parameter int unsigned NumPorts = 2,
    localparam int unsigned IdxW = idx_width(NumPorts)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumPorts-1:0] req_i,
    input  logic                lock_i,
    input  logic [IdxW-1:0]     lock_sel_i,
    input  logic                hs_i,
    output logic [IdxW-1:0]     sel_o,
    output logic                valid_o
);

    logic [IdxW-1:0] rr_ptr_q;

    // Scan from the highest offset down so the requester closest to the
    // pointer is the last (winning) assignment.
    always_comb begin
        int idx;
        sel_o   = rr_ptr_q;
        valid_o = 1'b0;
        idx     = 0;
        if (lock_i) begin
            sel_o   = lock_sel_i;
            valid_o = req_i[lock_sel_i];
        end else begin
            for (int i = int'(NumPorts) - 1; i >= 0; i--) begin
                idx = int'(rr_ptr_q) + i;
                if (idx >= int'(NumPorts)) idx = idx - int'(NumPorts);
                if (req_i[IdxW'(idx)]) begin
                    sel_o   = IdxW'(idx);
                    valid_o = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else if (hs_i) begin
            rr_ptr_q <= (sel_o == IdxW'(NumPorts - 1)) ? '0 : sel_o + 1'b1;
        end
    end

endmodule

// File: rtl/relobi_rr_mux.sv
// relobi_rr_mux
// Shares one OBI manager port between NumSbrPorts requesters with round-robin
// arbitration. Each granted transaction pushes its source index into an ID
// FIFO; every R beat is routed to the requester at the FIFO head.
//   clk_i, rst_ni    : clock, async active-low reset
//   sbr_ports_req_i  : requester requests
//   sbr_ports_rsp_o  : requester responses
//   mgr_port_req_o   : shared manager request
//   mgr_port_rsp_i   : shared manager response
//   fault_o          : single-cycle flag, R beat arrived with no outstanding ID
module relobi_rr_mux
    import relobi_pkg::*;
#(
    parameter obi_cfg_t    ObiCfg      = ObiDefaultConfig,
    parameter type         obi_req_t   = relobi_pkg::obi_req_t,
    parameter type         obi_rsp_t   = relobi_pkg::obi_rsp_t,
    parameter int unsigned NumSbrPorts = 2,
    parameter int unsigned MaxTrans    = 4
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  obi_req_t sbr_ports_req_i [NumSbrPorts],
    output obi_rsp_t sbr_ports_rsp_o [NumSbrPorts],
    output obi_req_t mgr_port_req_o,
    input  obi_rsp_t mgr_port_rsp_i,
    output logic     fault_o
);

    localparam int unsigned IdxW = idx_width(NumSbrPorts);
    localparam int unsigned PtrW = idx_width(MaxTrans);
    localparam int unsigned CntW = $clog2(MaxTrans + 1);

    typedef logic [IdxW-1:0] idx_t;
    typedef logic [PtrW-1:0] ptr_t;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == PtrW'(MaxTrans - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [NumSbrPorts-1:0] req_vec;
    idx_t                   sel, sel_q, head;
    logic                   arb_valid, lock_q;
    logic                   full, empty, mgr_req, hs, pop, r_ready;
    ptr_t                   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]        cnt_q;
    idx_t                   id_fifo_q [MaxTrans];

    always_comb begin
        for (int i = 0; i < int'(NumSbrPorts); i++) req_vec[i] = sbr_ports_req_i[i].req;
    end

    relobi_rr_arb #(
        .NumPorts (NumSbrPorts)
    ) u_arb (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_i      (req_vec),
        .lock_i     (lock_q),
        .lock_sel_i (sel_q),
        .hs_i       (hs),
        .sel_o      (sel),
        .valid_o    (arb_valid)
    );

    assign full    = (cnt_q == CntW'(MaxTrans));
    assign empty   = (cnt_q == '0);
    assign mgr_req = arb_valid & ~full;
    assign hs      = mgr_req & mgr_port_rsp_i.gnt;
    assign head    = id_fifo_q[rd_ptr_q];

    // With no outstanding ID a stray beat is accepted so it drains.
    assign r_ready = (empty || !ObiCfg.UseRReady) ? 1'b1 : sbr_ports_req_i[head].rready;
    assign pop     = mgr_port_rsp_i.rvalid & r_ready & ~empty;
    assign fault_o = mgr_port_rsp_i.rvalid & empty;

    always_comb begin
        mgr_port_req_o        = '0;
        mgr_port_req_o.req    = mgr_req;
        mgr_port_req_o.a      = sbr_ports_req_i[sel].a;
        mgr_port_req_o.rready = r_ready;
    end

    always_comb begin
        for (int i = 0; i < int'(NumSbrPorts); i++) begin
            sbr_ports_rsp_o[i]        = '0;
            sbr_ports_rsp_o[i].r      = mgr_port_rsp_i.r;
            sbr_ports_rsp_o[i].gnt    = hs && (sel == idx_t'(i));
            sbr_ports_rsp_o[i].rvalid = mgr_port_rsp_i.rvalid && !empty && (head == idx_t'(i));
        end
    end

    // Control state: lock, pointers, occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q   <= 1'b0;
            sel_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            // A request left waiting must keep its slot until granted.
            lock_q <= mgr_req & ~mgr_port_rsp_i.gnt;
            if (mgr_req && !mgr_port_rsp_i.gnt) sel_q <= sel;
            if (hs)  wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({hs, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // ID storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk_i) begin
        if (hs) id_fifo_q[wr_ptr_q] <= sel;
    end

endmodule

// File: tb/tb_relobi_rr_mux.sv
// tb_relobi_rr_mux
// Directed scenarios plus a randomized run against a transaction-level model
// (queue of outstanding source IDs, round-robin pointer, pending-request hold).
module tb_relobi_rr_mux;
    import relobi_pkg::*;

    localparam int N = 2;
    localparam int M = 4;

    logic     clk = 1'b0;
    logic     rst_ni = 1'b0;
    obi_req_t sbr_req [N];
    obi_rsp_t sbr_rsp [N];
    obi_req_t mreq;
    obi_rsp_t mrsp;
    logic     fault;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int m_rr;
    bit m_lock;
    int m_lsel;
    int m_q[$];

    always #5 clk = ~clk;

    relobi_rr_mux #(
        .ObiCfg      (ObiDefaultConfig),
        .obi_req_t   (obi_req_t),
        .obi_rsp_t   (obi_rsp_t),
        .NumSbrPorts (N),
        .MaxTrans    (M)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .sbr_ports_req_i (sbr_req),
        .sbr_ports_rsp_o (sbr_rsp),
        .mgr_port_req_o  (mreq),
        .mgr_port_rsp_i  (mrsp),
        .fault_o         (fault)
    );

    function automatic int exp_sel();
        if (m_q.size() >= M) return -1;
        if (m_lock) return sbr_req[m_lsel].req ? m_lsel : -1;
        for (int k = 0; k < N; k++) begin
            if (sbr_req[(m_rr + k) % N].req) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_rr = 0; m_lock = 0; m_lsel = 0; m_q.delete();
    endtask

    task automatic model_step();
        int  s;
        bit  do_pop;
        s = exp_sel();
        do_pop = mrsp.rvalid && (m_q.size() > 0) && sbr_req[m_q[0]].rready;
        if (s >= 0 && mrsp.gnt) begin
            m_q.push_back(s); m_rr = (s + 1) % N; m_lock = 0;
        end else if (s >= 0) begin
            m_lock = 1; m_lsel = s;
        end else begin
            m_lock = 0;
        end
        if (do_pop) void'(m_q.pop_front());
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < N; i++) sbr_req[i] = '0;
        mrsp = '0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        clear_inputs();
        model_reset();
        @(negedge clk);
        n_vec++; if (mreq.req !== 1'b0) begin n_err++; $display("FAIL reset_mreq got %0b want 0", mreq.req); end
        n_vec++; if ({sbr_rsp[1].gnt, sbr_rsp[0].gnt} !== 2'b00) begin n_err++; $display("FAIL reset_gnt got %b want 00", {sbr_rsp[1].gnt, sbr_rsp[0].gnt}); end
        n_vec++; if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault got %0b want 0", fault); end
        n_vec++; if (dut.cnt_q !== 3'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", dut.cnt_q); end
        @(posedge clk); #1 rst_ni = 1'b1;
        @(negedge clk);
        n_vec++; if (dut.u_arb.rr_ptr_q !== 1'b0) begin n_err++; $display("FAIL reset_rrptr got %0d want 0", dut.u_arb.rr_ptr_q); end
        n_vec++; if (mreq.req !== 1'b0 || fault !== 1'b0) begin n_err++; $display("FAIL idle_out got req=%0b fault=%0b want 0/0", mreq.req, fault); end
    endtask

    task automatic test_alternate();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < N; i++) begin
                sbr_req[i].req = (k < 4);
                sbr_req[i].a.addr = 32'h100 + i;
                sbr_req[i].rready = 1'b1;
            end
            mrsp.gnt = 1'b1;
            mrsp.rvalid = (k > 0);
            mrsp.r.rdata = 32'hD0 + k;
            @(negedge clk);
            if (k < 4) begin
                int g = k % 2;
                n_vec++; if (sbr_rsp[g].gnt !== 1'b1 || sbr_rsp[1-g].gnt !== 1'b0) begin n_err++; $display("FAIL alt_gnt k=%0d got %b want port %0d", k, {sbr_rsp[1].gnt, sbr_rsp[0].gnt}, g); end
                n_vec++; if (mreq.a.addr !== 32'h100 + g) begin n_err++; $display("FAIL alt_addr k=%0d got %0h want %0h", k, mreq.a.addr, 32'h100 + g); end
            end
            if (k > 0) begin
                int p = (k - 1) % 2;
                n_vec++; if (sbr_rsp[p].rvalid !== 1'b1 || sbr_rsp[1-p].rvalid !== 1'b0) begin n_err++; $display("FAIL alt_rvalid k=%0d got %b want port %0d", k, {sbr_rsp[1].rvalid, sbr_rsp[0].rvalid}, p); end
                n_vec++; if (sbr_rsp[p].r.rdata !== 32'hD0 + k) begin n_err++; $display("FAIL alt_rdata k=%0d got %0h want %0h", k, sbr_rsp[p].r.rdata, 32'hD0 + k); end
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_lock();
        do_reset();
        // Complete one transaction on port 0 so the pointer favours port 1.
        sbr_req[0].req = 1'b1; sbr_req[0].a.addr = 32'h10; sbr_req[0].rready = 1'b1;
        mrsp.gnt = 1'b1;
        @(negedge clk);
        n_vec++; if (sbr_rsp[0].gnt !== 1'b1) begin n_err++; $display("FAIL lock_prime got %0b want 1", sbr_rsp[0].gnt); end
        tick();
        sbr_req[0].req = 1'b0; mrsp.gnt = 1'b0; mrsp.rvalid = 1'b1;
        tick();
        mrsp.rvalid = 1'b0;
        sbr_req[1].rready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            sbr_req[0].req = 1'b1; sbr_req[0].a.addr = 32'hA0; sbr_req[0].a.wdata = 32'h5A5A;
            sbr_req[1].req = (c >= 1); sbr_req[1].a.addr = 32'hB1;
            mrsp.gnt = (c == 3);
            @(negedge clk);
            n_vec++; if (mreq.req !== 1'b1 || mreq.a.addr !== 32'hA0 || mreq.a.wdata !== 32'h5A5A) begin n_err++; $display("FAIL lock_a c=%0d got req=%0b addr=%0h want 1/a0", c, mreq.req, mreq.a.addr); end
            n_vec++; if ({sbr_rsp[1].gnt, sbr_rsp[0].gnt} !== ((c == 3) ? 2'b01 : 2'b00)) begin n_err++; $display("FAIL lock_gnt c=%0d got %b", c, {sbr_rsp[1].gnt, sbr_rsp[0].gnt}); end
            tick();
        end
        sbr_req[0].req = 1'b0;
        @(negedge clk);
        n_vec++; if (sbr_rsp[1].gnt !== 1'b1 || mreq.a.addr !== 32'hB1) begin n_err++; $display("FAIL lock_next got gnt1=%0b addr=%0h want 1/b1", sbr_rsp[1].gnt, mreq.a.addr); end
        tick();
        sbr_req[1].req = 1'b0; mrsp.gnt = 1'b0; mrsp.rvalid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_vec++; if (sbr_rsp[k].rvalid !== 1'b1 || sbr_rsp[1-k].rvalid !== 1'b0) begin n_err++; $display("FAIL lock_route k=%0d got %b", k, {sbr_rsp[1].rvalid, sbr_rsp[0].rvalid}); end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < N; i++) begin sbr_req[i].req = 1'b1; sbr_req[i].rready = 1'b1; end
        mrsp.gnt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_vec++; if (mreq.req !== 1'b1 || sbr_rsp[k%2].gnt !== 1'b1) begin n_err++; $display("FAIL full_fill k=%0d got req=%0b gnt=%b", k, mreq.req, {sbr_rsp[1].gnt, sbr_rsp[0].gnt}); end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            mrsp.rvalid = (k == 1);
            @(negedge clk);
            n_vec++; if (mreq.req !== 1'b0 || {sbr_rsp[1].gnt, sbr_rsp[0].gnt} !== 2'b00) begin n_err++; $display("FAIL full_block k=%0d got req=%0b gnt=%b want 0/00", k, mreq.req, {sbr_rsp[1].gnt, sbr_rsp[0].gnt}); end
            if (k == 1) begin
                n_vec++; if (sbr_rsp[0].rvalid !== 1'b1) begin n_err++; $display("FAIL full_pop got %0b want 1", sbr_rsp[0].rvalid); end
            end
            tick();
        end
        mrsp.rvalid = 1'b0;
        @(negedge clk);
        n_vec++; if (mreq.req !== 1'b1 || sbr_rsp[0].gnt !== 1'b1) begin n_err++; $display("FAIL full_resume got req=%0b gnt0=%0b want 1/1", mreq.req, sbr_rsp[0].gnt); end
        tick();
        for (int i = 0; i < N; i++) sbr_req[i].req = 1'b0;
        mrsp.gnt = 1'b0; mrsp.rvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int p = (k % 2 == 0) ? 1 : 0;
            @(negedge clk);
            n_vec++; if (sbr_rsp[p].rvalid !== 1'b1 || sbr_rsp[1-p].rvalid !== 1'b0) begin n_err++; $display("FAIL full_drain k=%0d got %b want port %0d", k, {sbr_rsp[1].rvalid, sbr_rsp[0].rvalid}, p); end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_push_pop();
        do_reset();
        for (int i = 0; i < N; i++) begin sbr_req[i].req = 1'b1; sbr_req[i].rready = 1'b1; end
        mrsp.gnt = 1'b1;
        tick(); tick();
        mrsp.rvalid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            int p = j % 2;
            @(negedge clk);
            n_vec++; if (sbr_rsp[p].rvalid !== 1'b1 || sbr_rsp[1-p].rvalid !== 1'b0) begin n_err++; $display("FAIL pp_route j=%0d got %b want port %0d", j, {sbr_rsp[1].rvalid, sbr_rsp[0].rvalid}, p); end
            n_vec++; if (sbr_rsp[p].gnt !== 1'b1) begin n_err++; $display("FAIL pp_gnt j=%0d got %b want port %0d", j, {sbr_rsp[1].gnt, sbr_rsp[0].gnt}, p); end
            tick();
            n_vec++; if (dut.cnt_q !== 3'd2) begin n_err++; $display("FAIL pp_cnt j=%0d got %0d want 2", j, dut.cnt_q); end
        end
        n_vec++; if (dut.rd_ptr_q !== 2'd0) begin n_err++; $display("FAIL pp_wrap got %0d want 0", dut.rd_ptr_q); end
        for (int i = 0; i < N; i++) sbr_req[i].req = 1'b0;
        mrsp.gnt = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_vec++; if (sbr_rsp[k].rvalid !== 1'b1 || sbr_rsp[1-k].rvalid !== 1'b0) begin n_err++; $display("FAIL pp_drain k=%0d got %b", k, {sbr_rsp[1].rvalid, sbr_rsp[0].rvalid}); end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_fault();
        do_reset();
        mrsp.rvalid = 1'b1;
        @(negedge clk);
        n_vec++; if (fault !== 1'b1) begin n_err++; $display("FAIL fault_flag got %0b want 1", fault); end
        n_vec++; if ({sbr_rsp[1].rvalid, sbr_rsp[0].rvalid} !== 2'b00 || mreq.rready !== 1'b1) begin n_err++; $display("FAIL fault_drain got rv=%b rready=%0b want 00/1", {sbr_rsp[1].rvalid, sbr_rsp[0].rvalid}, mreq.rready); end
        tick();
        mrsp.rvalid = 1'b0;
        sbr_req[1].req = 1'b1; sbr_req[1].rready = 1'b1; mrsp.gnt = 1'b1;
        @(negedge clk);
        n_vec++; if (fault !== 1'b0 || sbr_rsp[1].gnt !== 1'b1 || dut.cnt_q !== 3'd0) begin n_err++; $display("FAIL fault_after got fault=%0b gnt1=%0b cnt=%0d want 0/1/0", fault, sbr_rsp[1].gnt, dut.cnt_q); end
        tick();
        sbr_req[1].req = 1'b0; mrsp.gnt = 1'b0; mrsp.rvalid = 1'b1;
        @(negedge clk);
        n_vec++; if (fault !== 1'b0 || sbr_rsp[1].rvalid !== 1'b1) begin n_err++; $display("FAIL fault_normal got fault=%0b rv1=%0b want 0/1", fault, sbr_rsp[1].rvalid); end
        tick();
        // Outstanding ID lost to an asynchronous reset.
        mrsp.rvalid = 1'b0; sbr_req[0].req = 1'b1; mrsp.gnt = 1'b1;
        tick();
        clear_inputs();
        rst_ni = 1'b0; #2 rst_ni = 1'b1;
        model_reset();
        mrsp.rvalid = 1'b1;
        @(negedge clk);
        n_vec++; if (fault !== 1'b1 || sbr_rsp[0].rvalid !== 1'b0) begin n_err++; $display("FAIL fault_rst got fault=%0b rv0=%0b want 1/0", fault, sbr_rsp[0].rvalid); end
        tick();
        clear_inputs();
    endtask

    task automatic test_random();
        bit pend [N];
        do_reset();
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            int s, hd;
            logic [N-1:0] eg, er, gg, gr;
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    sbr_req[i].req     = ($urandom_range(0, 2) != 0);
                    sbr_req[i].a.addr  = $urandom;
                    sbr_req[i].a.we    = 1'($urandom_range(0, 1));
                    sbr_req[i].a.be    = 4'($urandom_range(0, 15));
                    sbr_req[i].a.wdata = $urandom;
                end
                sbr_req[i].rready = ($urandom_range(0, 3) != 0);
            end
            mrsp.gnt     = ($urandom_range(0, 2) != 0);
            mrsp.rvalid  = (m_q.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
            mrsp.r.rdata = $urandom;
            mrsp.r.err   = 1'($urandom_range(0, 1));
            @(negedge clk);
            s  = exp_sel();
            hd = (m_q.size() > 0) ? m_q[0] : -1;
            for (int i = 0; i < N; i++) begin
                eg[i] = (s == i) && mrsp.gnt;
                er[i] = mrsp.rvalid && (hd == i);
                gg[i] = sbr_rsp[i].gnt;
                gr[i] = sbr_rsp[i].rvalid;
            end
            n_vec++; if (mreq.req !== (s >= 0)) begin n_err++; $display("FAIL rnd_req c=%0d got %0b want %0b", c, mreq.req, (s >= 0)); end
            if (s >= 0) begin
                n_vec++; if (mreq.a !== sbr_req[s].a) begin n_err++; $display("FAIL rnd_a c=%0d got %0h want %0h", c, mreq.a, sbr_req[s].a); end
            end
            n_vec++; if (gg !== eg) begin n_err++; $display("FAIL rnd_gnt c=%0d got %b want %b", c, gg, eg); end
            n_vec++; if (gr !== er) begin n_err++; $display("FAIL rnd_rvalid c=%0d got %b want %b", c, gr, er); end
            n_vec++; if (mreq.rready !== ((hd < 0) ? 1'b1 : sbr_req[hd].rready)) begin n_err++; $display("FAIL rnd_rready c=%0d got %0b", c, mreq.rready); end
            n_vec++; if (fault !== (mrsp.rvalid && hd < 0)) begin n_err++; $display("FAIL rnd_fault c=%0d got %0b want %0b", c, fault, (mrsp.rvalid && hd < 0)); end
            for (int i = 0; i < N; i++) begin
                n_vec++; if (sbr_rsp[i].r !== mrsp.r) begin n_err++; $display("FAIL rnd_r c=%0d port %0d got %0h want %0h", c, i, sbr_rsp[i].r, mrsp.r); end
            end
            for (int i = 0; i < N; i++) pend[i] = sbr_req[i].req && !((s == i) && mrsp.gnt);
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_alternate();
        test_lock();
        test_full();
        test_push_pop();
        test_fault();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
